round_judge: RTL and testbench

Parametrised round-judging and match-scoring engine for the animal-battle game, succeeding the fixed three-choice cat/dog/chicken scenario decode in the top level. It takes two players' one-hot choices from an arbitrary odd-sized choice set and applies a cyclic beats-rule. It keeps saturating per-player scores, detects match end at a configurable target, and handshakes each result with the drawing controller. Score outputs drive the HEX displays directly; outcome flags replace the nine scenario signals.

---
 rtl/round_judge.sv | 101 ++++++++++
 tb/tb_round_judge.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/round_judge.sv
// round_judge: cyclic beats-rule round judge with saturating scores, match end and result handshake
module round_judge #(
   parameter int NUM_CHOICES = 3,
   parameter int SCORE_W = 4,
   parameter int WIN_SCORE = 9,
   localparam int IW = $clog2(NUM_CHOICES)
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic [NUM_CHOICES-1:0] choice1,
   input  logic [NUM_CHOICES-1:0] choice2,
   input  logic                   start,
   input  logic                   ack,
   input  logic                   clear_scores,
   output logic                   busy,
   output logic                   result_valid,
   output logic                   p1_win,
   output logic                   p2_win,
   output logic                   tie,
   output logic                   invalid1,
   output logic                   invalid2,
   output logic [IW-1:0]          idx1,
   output logic [IW-1:0]          idx2,
   output logic [SCORE_W-1:0]     score1,
   output logic [SCORE_W-1:0]     score2,
   output logic                   match_over,
   output logic [1:0]             match_winner
);
   typedef enum logic [2:0] {IDLE, JUDGE, SCORE, SHOW, OVER} state_t;
   localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);
   localparam logic [IW:0] N = (IW+1)'(NUM_CHOICES);
   localparam logic [IW:0] HALF = (IW+1)'((NUM_CHOICES - 1) / 2);
   state_t state;
   logic [IW:0] dec1, dec2, diff, d;
   // msb flags a non-one-hot choice, which falls back to index 0 (cat)
   function automatic logic [IW:0] decode(input logic [NUM_CHOICES-1:0] c);
      logic [IW-1:0] ix;
      ix = '0;
      for (int i = 0; i < NUM_CHOICES; i++)
         if (c[i]) ix = IW'(i);
      return (c != '0 && (c & (c - NUM_CHOICES'(1))) == '0) ? {1'b0, ix} : {1'b1, {IW{1'b0}}};
   endfunction
   assign dec1 = decode(choice1);
   assign dec2 = decode(choice2);
   assign diff = {1'b0, idx1} + N - {1'b0, idx2};
   assign d = diff >= N ? diff - N : diff;
   assign busy = state == JUDGE || state == SCORE || state == SHOW;
   assign result_valid = state == SHOW;
   assign match_over = state == OVER;
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         state <= IDLE;
         idx1 <= '0;
         idx2 <= '0;
         invalid1 <= 1'b0;
         invalid2 <= 1'b0;
         p1_win <= 1'b0;
         p2_win <= 1'b0;
         tie <= 1'b0;
         score1 <= '0;
         score2 <= '0;
         match_winner <= 2'b00;
      end else
         case (state)
            IDLE:
               if (clear_scores) begin
                  score1 <= '0;
                  score2 <= '0;
               end else if (start) begin
                  idx1 <= dec1[IW-1:0];
                  idx2 <= dec2[IW-1:0];
                  invalid1 <= dec1[IW];
                  invalid2 <= dec2[IW];
                  state <= JUDGE;
               end
            JUDGE: begin
               tie <= d == '0;
               p1_win <= d != '0 && d <= HALF;
               p2_win <= d > HALF;
               state <= SCORE;
            end
            SCORE: begin
               if (p1_win && score1 != WIN) score1 <= score1 + 1'b1;
               if (p2_win && score2 != WIN) score2 <= score2 + 1'b1;
               state <= SHOW;
            end
            SHOW:
               if (ack) begin
                  match_winner <= {score2 == WIN, score1 == WIN};
                  state <= (score1 == WIN || score2 == WIN) ? OVER : IDLE;
               end
            OVER:
               if (clear_scores) begin
                  score1 <= '0;
                  score2 <= '0;
                  match_winner <= 2'b00;
                  state <= IDLE;
               end
            default: state <= IDLE;
         endcase
endmodule

// File: tb/tb_round_judge.sv
// tb_round_judge: scoreboard bench for round_judge with 3- and 5-choice instances
module tb_round_judge;
   logic clk = 1'b0, resetn = 1'b0;
   logic [2:0] ch1 = '0, ch2 = '0;
   logic [4:0] ch1_5 = '0, ch2_5 = '0;
   logic start = 0, ack = 0, clr = 0, start5 = 0, ack5 = 0, clr5 = 0;
   logic busy, rv, p1, p2, tie, inv1, inv2, mo;
   logic [1:0] i1, i2, mw;
   logic [3:0] s1, s2;
   logic busy5, rv5, p1_5, p2_5, tie5, inv1_5, inv2_5, mo5;
   logic [2:0] i1_5, i2_5;
   logic [1:0] mw5;
   logic [3:0] s1_5, s2_5;
   logic [20:0] q3[$], q5[$];
   logic seen3 = 0, seen5 = 0;
   int checks = 0, errors = 0;
   int es1[2] = '{0, 0}, es2[2] = '{0, 0};

   always #5 clk = ~clk;

   round_judge u3 (.clk(clk), .resetn(resetn), .choice1(ch1), .choice2(ch2), .start(start), .ack(ack),
      .clear_scores(clr), .busy(busy), .result_valid(rv), .p1_win(p1), .p2_win(p2), .tie(tie),
      .invalid1(inv1), .invalid2(inv2), .idx1(i1), .idx2(i2), .score1(s1), .score2(s2),
      .match_over(mo), .match_winner(mw));

   round_judge #(.NUM_CHOICES(5)) u5 (.clk(clk), .resetn(resetn), .choice1(ch1_5), .choice2(ch2_5),
      .start(start5), .ack(ack5), .clear_scores(clr5), .busy(busy5), .result_valid(rv5), .p1_win(p1_5),
      .p2_win(p2_5), .tie(tie5), .invalid1(inv1_5), .invalid2(inv2_5), .idx1(i1_5), .idx2(i2_5),
      .score1(s1_5), .score2(s2_5), .match_over(mo5), .match_winner(mw5));

   task automatic cmp(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s got %h want %h", n, a, e);
      end
   endtask

   always @(negedge clk) begin
      if (rv && !seen3) begin
         if (q3.size() == 0) cmp("unexpected_result3", 1, 0);
         else cmp("result3", {p1, p2, tie, inv1, inv2, 2'b0, i1, 2'b0, i2, s1, s2}, q3.pop_front());
      end
      seen3 = rv;
   end

   always @(negedge clk) begin
      if (rv5 && !seen5) begin
         if (q5.size() == 0) cmp("unexpected_result5", 1, 0);
         else cmp("result5", {p1_5, p2_5, tie5, inv1_5, inv2_5, 1'b0, i1_5, 1'b0, i2_5, s1_5, s2_5}, q5.pop_front());
      end
      seen5 = rv5;
   end

   task automatic round(input bit f, input logic [4:0] c1, input logic [4:0] c2, input bit w1, input bit w2,
                        input bit t, input bit v1, input bit v2, input int x1, input int x2, input bit hold);
      int n;
      if (w1) es1[f]++;
      if (w2) es2[f]++;
      if (f) q5.push_back({w1, w2, t, v1, v2, 4'(x1), 4'(x2), 4'(es1[f]), 4'(es2[f])});
      else q3.push_back({w1, w2, t, v1, v2, 4'(x1), 4'(x2), 4'(es1[f]), 4'(es2[f])});
      @(posedge clk); #1;
      if (f) begin ch1_5 = c1; ch2_5 = c2; start5 = 1; end
      else begin ch1 = c1[2:0]; ch2 = c2[2:0]; start = 1; end
      @(posedge clk); #1;
      if (!hold) begin start = 0; start5 = 0; end
      ch1 = '0; ch2 = '0; ch1_5 = '0; ch2_5 = '0;
      cmp("busy_after_start", f ? busy5 : busy, 1);
      n = 0;
      while (!(f ? rv5 : rv) && n < 20) begin @(posedge clk); #1; n++; end
      cmp("rv_latency", n, 2);
      if (hold) repeat (2) begin @(posedge clk); #1; end
      start = 0; start5 = 0;
      if (f) ack5 = 1; else ack = 1;
      @(posedge clk); #1;
      ack = 0; ack5 = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      cmp("reset_status", {busy, rv, mo, mw, p1, p2, tie, inv1, inv2}, 0);
      cmp("reset_data", {i1, i2, s1, s2}, 0);
      resetn = 1;
      @(posedge clk); #1;
      // dog vs cat, then all nine valid pairs
      round(0, 5'b010, 5'b001, 1, 0, 0, 0, 0, 1, 0, 0);
      cmp("idle_after_ack", {busy, rv, mo}, 0);
      round(0, 5'b001, 5'b001, 0, 0, 1, 0, 0, 0, 0, 0);
      round(0, 5'b010, 5'b010, 0, 0, 1, 0, 0, 1, 1, 0);
      round(0, 5'b100, 5'b100, 0, 0, 1, 0, 0, 2, 2, 0);
      round(0, 5'b001, 5'b010, 0, 1, 0, 0, 0, 0, 1, 0);
      round(0, 5'b010, 5'b100, 0, 1, 0, 0, 0, 1, 2, 0);
      round(0, 5'b100, 5'b001, 0, 1, 0, 0, 0, 2, 0, 0);
      round(0, 5'b010, 5'b001, 1, 0, 0, 0, 0, 1, 0, 0);
      round(0, 5'b100, 5'b010, 1, 0, 0, 0, 0, 2, 1, 0);
      round(0, 5'b001, 5'b100, 1, 0, 0, 0, 0, 0, 2, 0);
      round(0, 5'b011, 5'b000, 0, 0, 1, 1, 1, 0, 0, 0);
      round(0, 5'b100, 5'b001, 0, 1, 0, 0, 0, 2, 0, 0);
      round(1, 5'b00001, 5'b01000, 1, 0, 0, 0, 0, 0, 3, 0);
      round(1, 5'b00001, 5'b00010, 0, 1, 0, 0, 0, 0, 1, 0);
      // clear beats a simultaneous start in IDLE
      clr = 1; start = 1;
      @(posedge clk); #1;
      clr = 0; start = 0;
      es1[0] = 0; es2[0] = 0;
      cmp("clear_in_idle", {busy, s1, s2}, 0);
      repeat (9) round(0, 5'b001, 5'b010, 0, 1, 0, 0, 0, 0, 1, 0);
      cmp("over_state", {mo, mw, s2, busy, rv}, {1'b1, 2'b10, 4'd9, 2'b00});
      start = 1; ack = 1;
      @(posedge clk); #1;
      start = 0; ack = 0;
      @(posedge clk); #1;
      cmp("over_ignores", {mo, mw, s1, s2, busy, rv, p2}, {1'b1, 2'b10, 4'd0, 4'd9, 3'b001});
      clr = 1;
      @(posedge clk); #1;
      clr = 0;
      es1[0] = 0; es2[0] = 0;
      cmp("clear_in_over", {mo, mw, busy, s1, s2}, 0);
      // start held through SHOW must not score twice
      round(0, 5'b010, 5'b001, 1, 0, 0, 0, 0, 1, 0, 1);
      repeat (3) @(posedge clk);
      #1;
      cmp("no_double_score", {busy, s1, s2}, {1'b0, 4'd1, 4'd0});
      ch1 = 3'b010; ch2 = 3'b001; start = 1;
      @(posedge clk); #1;
      start = 0;
      @(posedge clk); #1;
      resetn = 0;
      #1;
      cmp("midround_reset_status", {busy, rv, mo, mw, p1, p2, tie, inv1, inv2}, 0);
      cmp("midround_reset_data", {i1, i2, s1, s2}, 0);
      @(posedge clk); #1;
      cmp("reset_holds", {busy, s1, s2}, 0);
      resetn = 1;
      es1 = '{0, 0}; es2 = '{0, 0};
      round(0, 5'b001, 5'b100, 1, 0, 0, 0, 0, 0, 2, 0);
      repeat (3) @(posedge clk);
      #1;
      cmp("queues_drained", q3.size() + q5.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
